// File: rtl/peripheral_uart_fifo_wb.sv
// peripheral_uart_fifo_wb: Wishbone UART with 32-bit registers, TX/RX FIFOs and threshold interrupts.
module peripheral_uart_fifo_wb #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_WIDTH  = 16,
    parameter int DIV_RESET  = 26
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic [1:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic        wb_we_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic        wb_ack_o,
    output logic        int_o,
    input  logic        srx_pad_i,
    output logic        stx_pad_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic                 ack_q, int_q;
    logic [31:0]          dat_q;
    logic                 tx_en_q, rx_en_q, ie_rx_q, ie_tx_q, ie_err_q;
    logic [7:0]           thr_q;
    logic [DIV_WIDTH-1:0] div_q, dcnt_q;
    logic                 rx_ovr_q, frame_err_q, tx_ovf_q;
    logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
    logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
    logic [AW-1:0]        tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
    logic [CW-1:0]        tx_cnt_q, rx_cnt_q;
    state_t               tx_st_q, tx_st_d, rx_st_q, rx_st_d;
    logic [3:0]           tx_sub_q, tx_sub_d, rx_sub_q, rx_sub_d;
    logic [2:0]           tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
    logic                 tx_line_q, tx_line_d;
    logic [1:0]           rx_sync_q;
    logic                 rx_prev_q, rx_line;
    logic                 access, wr, rd, tick, tx_pop, tx_push, rx_pop, rx_push, rx_push_ok, rx_ferr;
    logic                 tx_empty, tx_full, rx_empty, rx_full, wr_sts;
    logic [31:0]          status, ctrl, rdata;
    logic [7:0]           thr_eff;
    logic                 unused_ok;

    assign access     = wb_stb_i & wb_cyc_i & ~ack_q;
    assign wr         = access & wb_we_i;
    assign rd         = access & ~wb_we_i;
    assign wr_sts     = wr & (wb_adr_i == 2'd1);
    assign tick       = dcnt_q == div_q;
    assign tx_empty   = tx_cnt_q == '0;
    assign tx_full    = tx_cnt_q == CW'(FIFO_DEPTH);
    assign rx_empty   = rx_cnt_q == '0;
    assign rx_full    = rx_cnt_q == CW'(FIFO_DEPTH);
    // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted
    assign tx_push    = wr & (wb_adr_i == 2'd0) & (~tx_full | tx_pop);
    assign rx_pop     = rd & (wb_adr_i == 2'd0) & ~rx_empty;
    assign rx_push_ok = rx_push & (~rx_full | rx_pop);
    assign rx_line    = rx_sync_q[1];
    assign thr_eff    = thr_q == 8'd0 ? 8'd1 : thr_q;
    assign status     = {8'd0, 8'(rx_cnt_q), 8'd0, tx_ovf_q, frame_err_q, rx_ovr_q,
                         tx_st_q != IDLE, tx_full, tx_empty, rx_full, rx_empty};
    assign ctrl       = {16'd0, thr_q, 3'd0, ie_err_q, ie_tx_q, ie_rx_q, rx_en_q, tx_en_q};
    assign rdata      = wb_adr_i == 2'd0 ? (rx_empty ? 32'd0 : 32'(rx_mem[rx_rp_q])) :
                        wb_adr_i == 2'd1 ? status : wb_adr_i == 2'd2 ? ctrl : 32'(div_q);
    assign unused_ok  = ^wb_dat_i;
    assign wb_ack_o   = ack_q;
    assign wb_dat_o   = dat_q;
    assign int_o      = int_q;
    assign stx_pad_o  = tx_line_q;

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            ack_q       <= 1'b0;
            dat_q       <= '0;
            int_q       <= 1'b0;
            tx_en_q     <= 1'b1;
            rx_en_q     <= 1'b1;
            ie_rx_q     <= 1'b0;
            ie_tx_q     <= 1'b0;
            ie_err_q    <= 1'b0;
            thr_q       <= 8'd1;
            div_q       <= DIV_WIDTH'(DIV_RESET);
            dcnt_q      <= '0;
            rx_ovr_q    <= 1'b0;
            frame_err_q <= 1'b0;
            tx_ovf_q    <= 1'b0;
        end else begin
            ack_q       <= access;
            dat_q       <= rd ? rdata : '0;
            int_q       <= (ie_rx_q & (9'(rx_cnt_q) >= 9'(thr_eff))) | (ie_tx_q & tx_empty) |
                           (ie_err_q & (rx_ovr_q | frame_err_q | tx_ovf_q));
            dcnt_q      <= (tick | (wr & wb_adr_i == 2'd3)) ? '0 : dcnt_q + 1'b1;
            if (wr & wb_adr_i == 2'd2) begin
                {ie_err_q, ie_tx_q, ie_rx_q, rx_en_q, tx_en_q} <= wb_dat_i[4:0];
                thr_q <= wb_dat_i[15:8];
            end
            if (wr & wb_adr_i == 2'd3) div_q <= wb_dat_i[DIV_WIDTH-1:0];
            rx_ovr_q    <= (rx_push & ~rx_push_ok) | (rx_ovr_q & ~(wr_sts & wb_dat_i[5]));
            frame_err_q <= rx_ferr | (frame_err_q & ~(wr_sts & wb_dat_i[6]));
            tx_ovf_q    <= (wr & wb_adr_i == 2'd0 & ~tx_push) | (tx_ovf_q & ~(wr_sts & wb_dat_i[7]));
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            tx_wp_q  <= '0;
            tx_rp_q  <= '0;
            tx_cnt_q <= '0;
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
            rx_cnt_q <= '0;
        end else begin
            tx_wp_q  <= tx_wp_q + AW'(tx_push);
            tx_rp_q  <= tx_rp_q + AW'(tx_pop);
            tx_cnt_q <= tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
            rx_wp_q  <= rx_wp_q + AW'(rx_push_ok);
            rx_rp_q  <= rx_rp_q + AW'(rx_pop);
            rx_cnt_q <= rx_cnt_q + CW'(rx_push_ok) - CW'(rx_pop);
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (tx_push) tx_mem[tx_wp_q] <= wb_dat_i[DATA_BITS-1:0];
        if (rx_push_ok) rx_mem[rx_wp_q] <= rx_sh_q;
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            tx_st_q   <= IDLE;
            tx_sub_q  <= '0;
            tx_bit_q  <= '0;
            tx_sh_q   <= '0;
            tx_line_q <= 1'b1;
            rx_st_q   <= IDLE;
            rx_sub_q  <= '0;
            rx_bit_q  <= '0;
            rx_sh_q   <= '0;
            rx_sync_q <= 2'b11;
            rx_prev_q <= 1'b1;
        end else begin
            tx_st_q   <= tx_st_d;
            tx_sub_q  <= tx_sub_d;
            tx_bit_q  <= tx_bit_d;
            tx_sh_q   <= tx_sh_d;
            tx_line_q <= tx_line_d;
            rx_st_q   <= rx_st_d;
            rx_sub_q  <= rx_sub_d;
            rx_bit_q  <= rx_bit_d;
            rx_sh_q   <= rx_sh_d;
            rx_sync_q <= {rx_sync_q[0], srx_pad_i};
            rx_prev_q <= rx_line;
        end
    end

    // The 4-bit tick counter wraps to 0 at each bit boundary, so it needs no explicit reload
    always_comb begin
        tx_st_d  = tx_st_q;
        tx_sub_d = tx_sub_q;
        tx_bit_d = tx_bit_q;
        tx_sh_d  = tx_sh_q;
        tx_pop   = 1'b0;
        case (tx_st_q)
            IDLE: if (tx_en_q & ~tx_empty) begin
                tx_pop  = 1'b1;
                tx_sh_d = tx_mem[tx_rp_q];
                tx_st_d = START;
            end
            START: if (tick) begin
                tx_sub_d = tx_sub_q + 4'd1;
                if (tx_sub_q == 4'd15) begin
                    tx_st_d  = DATA;
                    tx_bit_d = '0;
                end
            end
            DATA: if (tick) begin
                tx_sub_d = tx_sub_q + 4'd1;
                if (tx_sub_q == 4'd15) begin
                    tx_sh_d  = tx_sh_q >> 1;
                    tx_bit_d = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'(DATA_BITS - 1)) tx_st_d = STOP;
                end
            end
            default: if (tick) begin
                tx_sub_d = tx_sub_q + 4'd1;
                if (tx_sub_q == 4'd15) begin
                    tx_st_d = IDLE;
                    if (tx_en_q & ~tx_empty) begin
                        tx_pop  = 1'b1;
                        tx_sh_d = tx_mem[tx_rp_q];
                        tx_st_d = START;
                    end
                end
            end
        endcase
        tx_line_d = tx_st_d == START ? 1'b0 : tx_st_d == DATA ? tx_sh_d[0] : 1'b1;
    end

    // Start bit is checked at tick 8; every later sample lands 16 ticks on, at the bit midpoint
    always_comb begin
        rx_st_d  = rx_st_q;
        rx_sub_d = rx_sub_q;
        rx_bit_d = rx_bit_q;
        rx_sh_d  = rx_sh_q;
        rx_push  = 1'b0;
        rx_ferr  = 1'b0;
        case (rx_st_q)
            IDLE: if (rx_en_q & rx_prev_q & ~rx_line) begin
                rx_st_d  = START;
                rx_sub_d = '0;
            end
            START: if (tick) begin
                rx_sub_d = rx_sub_q + 4'd1;
                if (rx_sub_q == 4'd7) begin
                    rx_st_d  = rx_line ? IDLE : DATA;
                    rx_sub_d = '0;
                    rx_bit_d = '0;
                end
            end
            DATA: if (tick) begin
                rx_sub_d = rx_sub_q + 4'd1;
                if (rx_sub_q == 4'd15) begin
                    rx_sh_d  = {rx_line, rx_sh_q[DATA_BITS-1:1]};
                    rx_bit_d = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'(DATA_BITS - 1)) rx_st_d = STOP;
                end
            end
            default: if (tick) begin
                rx_sub_d = rx_sub_q + 4'd1;
                if (rx_sub_q == 4'd15) begin
                    rx_st_d = IDLE;
                    rx_push = rx_line;
                    rx_ferr = ~rx_line;
                end
            end
        endcase
    end
endmodule
